// File: rtl/gemv_stream_engine.sv
// gemv_stream_engine: tiled int GEMV core computing y = requant(W*x + b) row by row.
// x is buffered once per job; weight tiles stream in row-major order; each
// row result is requantized (mult/shift, optional ReLU, round, saturate) and
// streamed out before the next row's weights are accepted.
module gemv_stream_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int TILE_SIZE   = 32,
  parameter int MAX_ROWS    = 1024,
  parameter int MAX_COLS    = 1024,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(MAX_ROWS+1)-1:0]     rows,
  input  logic [$clog2(MAX_COLS+1)-1:0]     cols,
  input  logic                              relu_en,
  input  logic [MULT_WIDTH-1:0]             req_mult,
  input  logic [SHIFT_WIDTH-1:0]            req_shift,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]   x_tile,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]   w_tile,
  input  logic [DATA_WIDTH-1:0]             w_bias,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic [DATA_WIDTH-1:0]             y_data,
  output logic                              busy,
  output logic                              done
);

  localparam int LOG2T  = $clog2(TILE_SIZE);
  localparam int RW     = $clog2(MAX_ROWS+1);
  localparam int CW     = $clog2(MAX_COLS+1);
  localparam int NT_MAX = MAX_COLS / TILE_SIZE;
  localparam int TIDX_W = (NT_MAX > 1) ? $clog2(NT_MAX) : 1;
  localparam int LW     = TILE_SIZE * DATA_WIDTH;
  localparam int PSW    = 2 * DATA_WIDTH + LOG2T;
  localparam int PW     = ACC_WIDTH + MULT_WIDTH + 1;
  localparam int POSW   = CW + LOG2T + 1;

  localparam logic signed [PW-1:0] YMAX = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] YMIN = {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_X  = 3'd1,
    S_MAC     = 3'd2,
    S_DRAIN   = 3'd3,
    S_REQUANT = 3'd4,
    S_OUT     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  // Dot product of one tile; lanes at or beyond the job's column count are dropped.
  function automatic logic signed [PSW-1:0] masked_dot(
    input logic [LW-1:0] w,
    input logic [LW-1:0] x,
    input logic [CW-1:0] tile,
    input logic [CW-1:0] ncols
  );
    logic signed [PSW-1:0]          sum;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   wl;
    logic signed [DATA_WIDTH-1:0]   xl;
    logic [POSW-1:0]                pos;
    sum = {PSW{1'b0}};
    for (int i = 0; i < TILE_SIZE; i++) begin
      wl   = w[i*DATA_WIDTH +: DATA_WIDTH];
      xl   = x[i*DATA_WIDTH +: DATA_WIDTH];
      prod = wl * xl;
      pos  = (POSW'(tile) << LOG2T) + POSW'(i);
      if (pos < POSW'(ncols)) begin
        sum = sum + PSW'(prod);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Bias add, optional ReLU, fixed-point scale with round-half-up, saturate.
  function automatic logic [DATA_WIDTH-1:0] requant(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [DATA_WIDTH-1:0]  bias,
    input logic                   relu,
    input logic [MULT_WIDTH-1:0]  mult,
    input logic [SHIFT_WIDTH-1:0] shift
  );
    logic signed [ACC_WIDTH-1:0] v;
    logic signed [PW-1:0]        pv;
    logic signed [PW-1:0]        pm;
    logic signed [PW-1:0]        p;
    logic signed [PW-1:0]        q;
    logic [DATA_WIDTH-1:0]       res;
    v = $signed(acc + {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias});
    if (relu && v[ACC_WIDTH-1]) begin
      v = {ACC_WIDTH{1'b0}};
    end else begin
      v = v;
    end
    pv = PW'(v);
    pm = $signed({{(PW-MULT_WIDTH){1'b0}}, mult});
    p  = pv * pm;
    if (shift != {SHIFT_WIDTH{1'b0}}) begin
      p = p + (PW'(1'b1) << (shift - SHIFT_WIDTH'(1'b1)));
    end else begin
      p = p;
    end
    q = p >>> shift;
    if (q > YMAX) begin
      res = YMAX[DATA_WIDTH-1:0];
    end else if (q < YMIN) begin
      res = YMIN[DATA_WIDTH-1:0];
    end else begin
      res = q[DATA_WIDTH-1:0];
    end
    return res;
  endfunction

  state_t                  state_q, state_d;
  logic                    x_ready_q, x_ready_d;
  logic                    w_ready_q, w_ready_d;
  logic                    y_valid_q, y_valid_d;
  logic [DATA_WIDTH-1:0]   y_data_q, y_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [RW-1:0]           rows_q, rows_d;
  logic [CW-1:0]           cols_q, cols_d;
  logic                    relu_q, relu_d;
  logic [MULT_WIDTH-1:0]   mult_q, mult_d;
  logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   bias_q, bias_d;
  logic [CW-1:0]           x_idx_q, x_idx_d;
  logic [CW-1:0]           tile_idx_q, tile_idx_d;
  logic [RW-1:0]           row_idx_q, row_idx_d;
  logic signed [PSW-1:0]   psum_q, psum_d;
  logic                    psum_vld_q, psum_vld_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;

  logic [LW-1:0]           x_buf_q [NT_MAX];
  logic [LW-1:0]           x_rd_s;
  logic [CW:0]             ntiles_w_s;
  logic [CW-1:0]           ntiles_s;
  logic                    x_hs_s;
  logic                    w_hs_s;
  logic                    y_hs_s;

  assign x_ready = x_ready_q;
  assign w_ready = w_ready_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

  assign x_hs_s     = x_valid & x_ready_q;
  assign w_hs_s     = w_valid & w_ready_q;
  assign y_hs_s     = y_valid_q & y_ready;
  assign ntiles_w_s = ({1'b0, cols_q} + (CW+1)'(TILE_SIZE-1)) >> LOG2T;
  assign ntiles_s   = CW'(ntiles_w_s);
  assign x_rd_s     = x_buf_q[tile_idx_q[TIDX_W-1:0]];

  // x tile buffer: written once per job during LOAD_X, no reset needed.
  always_ff @(posedge clk) begin
    if (x_hs_s) begin
      x_buf_q[x_idx_q[TIDX_W-1:0]] <= x_tile;
    end
  end

  // Next-state logic: control FSM, two-stage MAC pipeline and requant.
  always_comb begin
    state_d    = state_q;
    x_ready_d  = x_ready_q;
    w_ready_d  = w_ready_q;
    y_valid_d  = y_valid_q;
    y_data_d   = y_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    relu_d     = relu_q;
    mult_d     = mult_q;
    shift_d    = shift_q;
    bias_d     = bias_q;
    x_idx_d    = x_idx_q;
    tile_idx_d = tile_idx_q;
    row_idx_d  = row_idx_q;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    acc_d      = acc_q;

    // Stage 1: register the masked tile dot product.
    if (w_hs_s) begin
      psum_d     = masked_dot(w_tile, x_rd_s, tile_idx_q, cols_q);
      psum_vld_d = 1'b1;
    end else begin
      psum_d     = psum_q;
    end

    // Stage 2: fold the previous tile's partial sum into the row accumulator.
    if (psum_vld_q) begin
      acc_d = acc_q + ACC_WIDTH'(psum_q);
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((rows != {RW{1'b0}}) && (cols != {CW{1'b0}})) begin
            rows_d    = rows;
            cols_d    = cols;
            relu_d    = relu_en;
            mult_d    = req_mult;
            shift_d   = req_shift;
            busy_d    = 1'b1;
            x_ready_d = 1'b1;
            x_idx_d   = {CW{1'b0}};
            state_d   = S_LOAD_X;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_X: begin
        if (x_hs_s) begin
          if (x_idx_q == ntiles_s - CW'(1)) begin
            x_ready_d  = 1'b0;
            w_ready_d  = 1'b1;
            row_idx_d  = {RW{1'b0}};
            tile_idx_d = {CW{1'b0}};
            acc_d      = {ACC_WIDTH{1'b0}};
            state_d    = S_MAC;
          end else begin
            x_idx_d = x_idx_q + CW'(1);
          end
        end else begin
          state_d = S_LOAD_X;
        end
      end
      S_MAC: begin
        if (w_hs_s) begin
          if (tile_idx_q == ntiles_s - CW'(1)) begin
            bias_d    = w_bias;
            w_ready_d = 1'b0;
            state_d   = S_DRAIN;
          end else begin
            tile_idx_d = tile_idx_q + CW'(1);
          end
        end else begin
          state_d = S_MAC;
        end
      end
      S_DRAIN: begin
        state_d = S_REQUANT;
      end
      S_REQUANT: begin
        y_data_d  = requant(acc_q, bias_q, relu_q, mult_q, shift_q);
        y_valid_d = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (y_hs_s) begin
          y_valid_d = 1'b0;
          if (row_idx_q == rows_q - RW'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            row_idx_d  = row_idx_q + RW'(1);
            tile_idx_d = {CW{1'b0}};
            acc_d      = {ACC_WIDTH{1'b0}};
            w_ready_d  = 1'b1;
            state_d    = S_MAC;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        x_ready_d = 1'b0;
        w_ready_d = 1'b0;
        y_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_ready_q  <= 1'b0;
      w_ready_q  <= 1'b0;
      y_valid_q  <= 1'b0;
      y_data_q   <= {DATA_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rows_q     <= {RW{1'b0}};
      cols_q     <= {CW{1'b0}};
      relu_q     <= 1'b0;
      mult_q     <= {MULT_WIDTH{1'b0}};
      shift_q    <= {SHIFT_WIDTH{1'b0}};
      bias_q     <= {DATA_WIDTH{1'b0}};
      x_idx_q    <= {CW{1'b0}};
      tile_idx_q <= {CW{1'b0}};
      row_idx_q  <= {RW{1'b0}};
      psum_q     <= {PSW{1'b0}};
      psum_vld_q <= 1'b0;
      acc_q      <= {ACC_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      x_ready_q  <= x_ready_d;
      w_ready_q  <= w_ready_d;
      y_valid_q  <= y_valid_d;
      y_data_q   <= y_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      relu_q     <= relu_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      bias_q     <= bias_d;
      x_idx_q    <= x_idx_d;
      tile_idx_q <= tile_idx_d;
      row_idx_q  <= row_idx_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      acc_q      <= acc_d;
    end
  end

endmodule
